alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: N, 32, operand/result width in bits; N >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 in_a  input  N  operand A.
REQ-007 in_b  input  N  operand B; shift amount is in_b[$clog2(N)-1:0].
REQ-008 in_op  input  4  ALUControl opcode.
REQ-009 out_valid  output  1  result/flags present.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_result  output  N  operation result.
REQ-012 out_flags  output  4  {N,Z,C,V}, bit3 = N.

Function
REQ-013 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 XOR, 5 NOT (~A), 6 LSA (A<<sh), 7 RSA (arithmetic A>>>sh), 8 LSL, 9 RSL (logical A>>sh), 10 DIV (unsigned A/B, quotient); 11-15 reserved.
REQ-014 Request accepted on a rising edge with in_valid && in_ready; operands and opcode captured then; inputs ignored otherwise.
REQ-015 States: IDLE, DIV_RUN, DONE; in_ready = 1 only in IDLE.
REQ-016 IDLE + accept, op != 10 (or DIV with B = 0) -> DONE; out_valid asserted the next cycle (latency 1).
REQ-017 IDLE + accept, op 10, B != 0 -> DIV_RUN; iterative restoring divide, one quotient bit per cycle, N cycles; then DONE (out_valid N+1 cycles after accept).
REQ-018 DONE: out_valid = 1; out_result/out_flags stable until out_ready; out_valid && out_ready -> IDLE; no new accept in that same cycle.
REQ-019 N = result MSB; Z = (result == 0), for every opcode.
REQ-020 ADD: C = carry out of bit N-1; V = signed overflow (A,B same sign, result differs).
REQ-021 SUB: A + ~B + 1; C = 1 when no borrow (A >= B unsigned); V = signed overflow (A,B differ in sign, result sign differs from A).
REQ-022 Logic, NOT, shift, DIV ops: C = 0, V = 0; shift amount 0 passes A unchanged.
REQ-023 DIV by zero: result all ones, flags {1,0,0,1}, latency 1.
REQ-024 Reserved opcode: result 0, flags 4'b0100, latency 1.
REQ-025 Arithmetic width: N-bit wrap-around; only C captures bit N.

Reset
REQ-026 rst_n low: state IDLE, out_valid 0, out_result 0, out_flags 0, divider registers 0; in_ready 1 once rst_n high.
REQ-027 Reset mid-DIV_RUN or in DONE abandons the operation; no out_valid pulse for it after release.

Structure
REQ-028 Shared package alu_pkg: opcode enum (ADD..DIV), flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), state enum.
REQ-029 Single sub-module div_seq: start/busy/done, N-bit dividend/divisor in, quotient out, same clk/rst_n.
REQ-030 Single-cycle ops computed combinationally from captured operands, registered into DONE outputs.

Verification (N = 4)
REQ-031 ADD A=0100 B=0010, out_ready=1 -> out_valid 1 cycle after accept, result 0110, flags 0000; ADD 0111+0001 -> 1000, flags 1001.
REQ-032 SUB 0100-0010 -> 0010, flags 0010; SUB 0000-0001 -> 1111, flags 1000.
REQ-033 RSA A=1100 sh=2 -> 1111, flags 1000; RSL A=1100 sh=2 -> 0011, flags 0000; LSL 1100 sh=2 -> 0000, flags 0100.
REQ-034 DIV 1000/0010 -> result 0100, out_valid exactly 5 cycles after accept, in_ready 0 throughout; DIV by 0 -> 1111, flags 1001 after 1 cycle.
REQ-035 Backpressure: out_ready held 0 for 3 cycles in DONE -> result/flags stable, in_ready 0, new in_valid not accepted until handshake completes.
REQ-036 rst_n pulsed low during DIV_RUN -> out_valid 0, state IDLE, in_ready 1 after release, next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the ALU execution unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_ORR = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_LSA = 4'd6,
    OP_RSA = 4'd7,
    OP_LSL = 4'd8,
    OP_RSL = 4'd9,
    OP_DIV = 4'd10
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] FLAGS_DIV0 = 4'b1001;
  localparam logic [3:0] FLAGS_RSVD = 4'b0100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/div_seq.sv
// Iterative restoring unsigned divider: one quotient bit per clock, N clocks per divide.
module div_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  rem_r;
  logic [N-1:0]  quo_r;
  logic [N-1:0]  dvs_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic [N:0]    shift_s;
  logic [N:0]    trial_s;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shift_s = {rem_r, quo_r[N-1]};
    trial_s = shift_s - {1'b0, dvs_r};
  end

  // Divider state: load on start, then shift/subtract while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      rem_r  <= '0;
      quo_r  <= dividend;
      dvs_r  <= divisor;
      cnt_r  <= CW'(N);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      // A clear borrow bit means the divisor fit: keep the difference and emit a 1.
      rem_r  <= trial_s[N] ? shift_s[N-1:0] : trial_s[N-1:0];
      quo_r  <= {quo_r[N-2:0], ~trial_s[N]};
      cnt_r  <= cnt_r - CW'(1);
      busy_r <= (cnt_r != CW'(1));
    end
  end

  assign busy     = busy_r;
  assign done     = busy_r && (cnt_r == CW'(1));
  assign quotient = quo_r;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops with registered result/flags, plus a
// sequential divider; valid/ready handshakes on both request and result sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [3:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_flags
);

  localparam int SW = $clog2(N);

  state_e        state_r, state_n;
  logic [N-1:0]  a_r, b_r;
  logic [3:0]    op_r;
  logic          in_ready_r, out_valid_r;
  logic [N-1:0]  out_result_r;
  logic [3:0]    out_flags_r;
  logic          accept_s, div_start_s, div_busy_s, div_done_s;
  logic [N-1:0]  quo_s, res_s;
  logic [N:0]    add_s, sub_s;
  logic [SW-1:0] sh_s;
  logic          carry_s, ovf_s, div0_s, rsvd_s;
  logic [3:0]    flags_s;

  assign accept_s    = in_valid && in_ready_r;
  assign div_start_s = accept_s && (in_op == OP_DIV) && (in_b != '0);
  assign add_s       = {1'b0, a_r} + {1'b0, b_r};
  assign sub_s       = {1'b0, a_r} + {1'b0, ~b_r} + {{N{1'b0}}, 1'b1};
  assign sh_s        = b_r[SW-1:0];
  assign div0_s      = (op_r == OP_DIV) && (b_r == '0);
  assign rsvd_s      = (op_r > OP_DIV);

  div_seq #(.N(N)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_s),
    .dividend (in_a),
    .divisor  (in_b),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (quo_s)
  );

  // Result and flag computation from the captured operands.
  always_comb begin
    res_s   = '0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    flags_s = 4'b0000;
    case (op_r)
      OP_ADD: begin
        res_s   = add_s[N-1:0];
        carry_s = add_s[N];
        ovf_s   = (a_r[N-1] == b_r[N-1]) && (add_s[N-1] != a_r[N-1]);
      end
      OP_SUB: begin
        res_s   = sub_s[N-1:0];
        carry_s = sub_s[N];
        ovf_s   = (a_r[N-1] != b_r[N-1]) && (sub_s[N-1] != a_r[N-1]);
      end
      OP_AND:         res_s = a_r & b_r;
      OP_ORR:         res_s = a_r | b_r;
      OP_XOR:         res_s = a_r ^ b_r;
      OP_NOT:         res_s = ~a_r;
      OP_LSA, OP_LSL: res_s = a_r << sh_s;
      OP_RSA:         res_s = $signed(a_r) >>> sh_s;
      OP_RSL:         res_s = a_r >> sh_s;
      OP_DIV:         res_s = div0_s ? '1 : quo_s;
      default:        res_s = '0;
    endcase
    if (div0_s) begin
      flags_s = FLAGS_DIV0;
    end else if (rsvd_s) begin
      flags_s = FLAGS_RSVD;
    end else begin
      flags_s[FLAG_N] = res_s[N-1];
      flags_s[FLAG_Z] = (res_s == '0);
      flags_s[FLAG_C] = carry_s;
      flags_s[FLAG_V] = ovf_s;
    end
  end

  // Next-state logic for the request/result sequencing.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n = div_start_s ? DIV_RUN : DONE;
        end else begin
          state_n = IDLE;
        end
      end
      DIV_RUN: begin
        if (div_done_s) begin
          state_n = DONE;
        end else if (!div_busy_s) begin
          state_n = IDLE;
        end else begin
          state_n = DIV_RUN;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and request-side ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n == IDLE);
    end
  end

  // Operand capture on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      op_r <= 4'd0;
    end else if (accept_s) begin
      a_r  <= in_a;
      b_r  <= in_b;
      op_r <= in_op;
    end
  end

  // Result holding registers: loaded on the first DONE cycle, held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_result_r <= '0;
      out_flags_r  <= 4'b0000;
    end else if ((state_r == DONE) && !out_valid_r) begin
      out_valid_r  <= 1'b1;
      out_result_r <= res_s;
      out_flags_r  <= flags_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_flags  = out_flags_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (N=4): directed and random requests against
// an arithmetic reference model, with random result backpressure and a mid-divide reset.
module tb_alu_exec_unit;

  localparam int N = 4;
  localparam int M = 1 << N;

  typedef struct {
    logic [N-1:0] res;
    logic [3:0]   flg;
    int           lat;
    longint       t_acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic [3:0]   in_op = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_result;
  logic [3:0]   out_flags;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   rand_bp = 1'b0;
  int   stall = 0;

  alu_exec_unit #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model from the arithmetic definition of each opcode.
  function automatic void ref_model(input int op, input int a, input int b,
                                    output logic [N-1:0] res, output logic [3:0] flg,
                                    output int lat);
    int sa, sb, r, sh;
    bit c, v;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    sh = b % N;
    lat = 1;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin r = a + b; c = (r >= M); v = (sa + sb > M / 2 - 1) || (sa + sb < -M / 2); end
      1: begin r = a - b; c = (a >= b); v = (sa - sb > M / 2 - 1) || (sa - sb < -M / 2); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = M - 1 - a;
      6, 8: r = a * (1 << sh);
      7: r = sa >>> sh;
      9: r = a / (1 << sh);
      10: begin
        if (b == 0) begin
          res = N'(M - 1);
          flg = 4'b1001;
          return;
        end
        r = a / b;
        lat = N + 1;
      end
      default: begin
        res = '0;
        flg = 4'b0100;
        return;
      end
    endcase
    r = ((r % M) + M) % M;
    res = r[N-1:0];
    flg = {res[N-1], res == '0, c, v};
  endfunction

  // Issue one request from a drive point (2 time units after a rising edge).
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int w;
    ref_model(int'(op), int'(a), int'(b), e.res, e.flg, e.lat);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    w = 0;
    while (!in_ready && w < 60) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.t_acc = $time;
    q.push_back(e);
    #2;
    in_valid = 1'b0;
  endtask

  // Result-side ready: forced stalls for directed backpressure, random otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: pops expectations when a result appears, checks latency and stability.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() == 0) && !have_cur});
      if (out_valid) begin
        if (!have_cur) begin
          if (q.size() == 0) begin
            chk("spurious_valid", {31'd0, out_valid}, 32'd0);
          end else begin
            cur = q.pop_front();
            have_cur = 1'b1;
            chk("result", {28'd0, out_result}, {28'd0, cur.res});
            chk("flags", {28'd0, out_flags}, {28'd0, cur.flg});
            chk("latency", 32'(($time - cur.t_acc - 5) / 10), 32'(cur.lat));
          end
        end else begin
          chk("stable_result", {28'd0, out_result}, {28'd0, cur.res});
          chk("stable_flags", {28'd0, out_flags}, {28'd0, cur.flg});
        end
        if (have_cur && out_ready) have_cur = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } req_t;

  req_t dir[$];

  initial begin
    int w;
    dir = '{
      '{4'd0,  4'b0100, 4'b0010}, '{4'd0,  4'b0111, 4'b0001},
      '{4'd1,  4'b0100, 4'b0010}, '{4'd1,  4'b0000, 4'b0001},
      '{4'd7,  4'b1100, 4'd2},    '{4'd9,  4'b1100, 4'd2},
      '{4'd8,  4'b1100, 4'd2},    '{4'd6,  4'b0011, 4'd0},
      '{4'd10, 4'b1000, 4'b0010}, '{4'd10, 4'b0111, 4'b0000},
      '{4'd10, 4'b1111, 4'b0001}, '{4'd12, 4'b0101, 4'b0011},
      '{4'd5,  4'b1010, 4'b0000}, '{4'd0,  4'b1000, 4'b1000}
    };

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {28'd0, out_result}, 32'd0);
    chk("rst_out_flags", {28'd0, out_flags}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b);

    // Backpressure: result held while a new request waits behind it.
    stall = 5;
    issue(4'd0, 4'b0011, 4'b0100);
    issue(4'd4, 4'b0101, 4'b0110);
    stall = 4;
    issue(4'd10, 4'b1101, 4'b0011);
    issue(4'd2, 4'b1100, 4'b1010);

    // Reset in the middle of a divide.
    w = 0;
    while ((q.size() != 0 || have_cur) && w < 100) begin
      @(posedge clk);
      #2;
      w++;
    end
    issue(4'd10, 4'b1001, 4'b0010);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    have_cur = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_result", {28'd0, out_result}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    issue(4'd0, 4'b0010, 4'b0011);

    // Random traffic with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), N'($urandom_range(0, M - 1)), N'($urandom_range(0, M - 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #2;
      end
    end

    w = 0;
    while ((q.size() != 0 || have_cur) && w < 300) begin
      @(posedge clk);
      #2;
      w++;
    end
    chk("drain", 32'(q.size()) + {31'd0, have_cur}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
